// File: rtl/row_scatter_slot.sv
// One-entry holding register with a valid/ready handshake for a single destination row.
// A drain and a refill in the same cycle keep the slot FULL and load the new word.
module row_scatter_slot #(
  parameter int COLS = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_fill,
  input  logic [COLS-1:0] i_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [COLS-1:0] o_data,
  output logic            o_free
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e     r_state;
  slot_state_e     w_stateNext;
  logic [COLS-1:0] r_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The top only raises i_fill when o_free is high, so a stalled FULL slot never sees a fill.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      EMPTY:   if (i_fill) w_stateNext = FULL;
      FULL:    if (i_ready && !i_fill) w_stateNext = EMPTY;
      default: w_stateNext = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= '0;
    end else if (i_fill) begin
      r_data <= i_data;
    end
  end

  assign o_valid = (r_state == FULL);
  assign o_data  = r_data;
  assign o_free  = (r_state == EMPTY) || i_ready;

endmodule

// File: rtl/row_scatter.sv
// Delivers a stream of row-tagged words to per-row holding slots, with broadcast,
// a sticky out-of-range index flag and an incrementally maintained occupancy count.
module row_scatter #(
  parameter int ROWS = 8,
  parameter int COLS = 2,
  parameter int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            InValid,
  output logic            InReady,
  input  logic [IDXW-1:0] InIdx,
  input  logic            InBcast,
  input  logic [COLS-1:0] InData,
  output logic [ROWS-1:0] OutValid,
  input  logic [ROWS-1:0] OutReady,
  output logic [COLS-1:0] OutData [ROWS-1:0],
  output logic [IDXW:0]   Pending,
  output logic            IdxErr
);

  localparam logic [IDXW:0] CntOne = (IDXW + 1)'(1);
  localparam logic [IDXW:0] CntAll = (IDXW + 1)'(ROWS);

  logic [ROWS-1:0] w_free;
  logic [ROWS-1:0] w_sel;
  logic [ROWS-1:0] w_fill;
  logic [ROWS-1:0] w_drain;
  logic            w_inRange;
  logic            w_allFree;
  logic            w_selFree;
  logic            w_accept;
  logic            w_grow;
  logic [IDXW:0]   w_shrink;
  logic [IDXW:0]   w_pendNext;
  logic [IDXW:0]   r_pending;
  logic            r_idxErr;

  // One-hot row decode; an index past ROWS-1 selects nothing, which is how out-of-range is detected.
  always_comb begin
    w_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_sel[r] = (ROWS == 1) || (InIdx == IDXW'(r));
    end
  end

  assign w_inRange = |w_sel;
  assign w_allFree = &w_free;
  assign w_selFree = |(w_sel & w_free);
  assign InReady   = InBcast ? w_allFree : (!w_inRange || w_selFree);
  assign w_accept  = InValid && InReady;
  assign w_fill    = w_accept ? (InBcast ? {ROWS{1'b1}} : w_sel) : '0;
  assign w_drain   = OutValid & OutReady & ~w_fill;
  assign w_grow    = |(w_fill & ~OutValid);

  always_comb begin
    w_shrink = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (w_drain[r]) w_shrink = w_shrink + CntOne;
    end
  end

  // A refilled row is neither a grow nor a shrink, so drain-and-refill nets to zero.
  assign w_pendNext = (w_accept && InBcast) ? CntAll
                    : r_pending + (w_grow ? CntOne : '0) - w_shrink;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= '0;
      r_idxErr  <= 1'b0;
    end else begin
      r_pending <= w_pendNext;
      if (w_accept && !InBcast && !w_inRange) r_idxErr <= 1'b1;
    end
  end

  assign Pending = r_pending;
  assign IdxErr  = r_idxErr;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    row_scatter_slot #(
      .COLS(COLS)
    ) u_slot (
      .clk    (clk),
      .resetn (resetn),
      .i_fill (w_fill[r]),
      .i_data (InData),
      .o_valid(OutValid[r]),
      .i_ready(OutReady[r]),
      .o_data (OutData[r]),
      .o_free (w_free[r])
    );
  end

endmodule

// File: tb/tb_row_scatter.sv
// Randomized and directed bench for row_scatter: an 8-row and a 6-row instance share one
// input stream and are both compared each cycle against a row-array reference model.
module tb_row_scatter;

  localparam int COLS = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            inValid;
  logic            inBcast;
  logic [2:0]      inIdx;
  logic [COLS-1:0] inData;
  logic [7:0]      outReady8;
  logic [5:0]      outReady6;
  logic            inReady8, inReady6;
  logic            idxErr8, idxErr6;
  logic [7:0]      outValid8;
  logic [5:0]      outValid6;
  logic [COLS-1:0] outData8 [7:0];
  logic [COLS-1:0] outData6 [5:0];
  logic [3:0]      pending8, pending6;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: index 0 is the 8-row instance, index 1 the 6-row instance.
  int              rowsOf [2] = '{8, 6};
  bit              mValid [2][8];
  logic [COLS-1:0] mData  [2][8];
  bit              mErr   [2];

  always #5 clk = ~clk;

  row_scatter #(.ROWS(8), .COLS(COLS)) u8 (
    .clk(clk), .resetn(resetn), .InValid(inValid), .InReady(inReady8), .InIdx(inIdx),
    .InBcast(inBcast), .InData(inData), .OutValid(outValid8), .OutReady(outReady8),
    .OutData(outData8), .Pending(pending8), .IdxErr(idxErr8)
  );

  row_scatter #(.ROWS(6), .COLS(COLS)) u6 (
    .clk(clk), .resetn(resetn), .InValid(inValid), .InReady(inReady6), .InIdx(inIdx),
    .InBcast(inBcast), .InData(inData), .OutValid(outValid6), .OutReady(outReady6),
    .OutData(outData6), .Pending(pending6), .IdxErr(idxErr6)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      mErr[k] = 1'b0;
      for (int r = 0; r < 8; r++) begin
        mValid[k][r] = 1'b0;
        mData[k][r]  = '0;
      end
    end
  endtask

  function automatic bit expReady(int k, logic [7:0] rdy);
    if (inBcast) begin
      for (int r = 0; r < rowsOf[k]; r++) begin
        if (mValid[k][r] && !rdy[r]) return 1'b0;
      end
      return 1'b1;
    end
    if (int'(inIdx) >= rowsOf[k]) return 1'b1;
    return !mValid[k][inIdx] || rdy[inIdx];
  endfunction

  task automatic checkRegs();
    logic [7:0] expV;
    int         cnt;
    for (int k = 0; k < 2; k++) begin
      expV = '0;
      cnt  = 0;
      for (int r = 0; r < rowsOf[k]; r++) begin
        expV[r] = mValid[k][r];
        cnt += int'(mValid[k][r]);
      end
      if (k == 0) begin
        checkOutput("valid8", 32'(outValid8), 32'(expV));
        checkOutput("pending8", 32'(pending8), cnt);
        checkOutput("idxErr8", 32'(idxErr8), 32'(mErr[0]));
        for (int r = 0; r < 8; r++)
          if (mValid[0][r]) checkOutput($sformatf("data8[%0d]", r), 32'(outData8[r]), 32'(mData[0][r]));
      end else begin
        checkOutput("valid6", 32'(outValid6), 32'(expV));
        checkOutput("pending6", 32'(pending6), cnt);
        checkOutput("idxErr6", 32'(idxErr6), 32'(mErr[1]));
        for (int r = 0; r < 6; r++)
          if (mValid[1][r]) checkOutput($sformatf("data6[%0d]", r), 32'(outData6[r]), 32'(mData[1][r]));
      end
    end
  endtask

  // Called just after a falling edge: drive, check InReady, advance model at the rising edge,
  // then check registered outputs at the next falling edge.
  task automatic applyStimulus(input bit v, input logic [2:0] idx, input bit bc,
                               input logic [COLS-1:0] d, input logic [7:0] rdy);
    bit acc [2];
    inValid   = v;
    inIdx     = idx;
    inBcast   = bc;
    inData    = d;
    outReady8 = rdy;
    outReady6 = rdy[5:0];
    #1;
    checkOutput("ready8", 32'(inReady8), 32'(expReady(0, rdy)));
    checkOutput("ready6", 32'(inReady6), 32'(expReady(1, rdy)));
    for (int k = 0; k < 2; k++) acc[k] = v && expReady(k, rdy);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < rowsOf[k]; r++) begin
        if (acc[k] && (bc || int'(idx) == r)) begin
          mValid[k][r] = 1'b1;
          mData[k][r]  = d;
        end else if (mValid[k][r] && rdy[r]) begin
          mValid[k][r] = 1'b0;
        end
      end
      if (acc[k] && !bc && int'(idx) >= rowsOf[k]) mErr[k] = 1'b1;
    end
    @(negedge clk);
    checkRegs();
  endtask

  initial begin
    logic [7:0] oneHot;
    resetn    = 1'b0;
    inValid   = 1'b0;
    inBcast   = 1'b0;
    inIdx     = '0;
    inData    = '0;
    outReady8 = '0;
    outReady6 = '0;
    resetModel();
    repeat (2) @(negedge clk);
    checkRegs();
    resetn = 1'b1;

    // Unicast to row 5, then a blocked second word to the same row.
    applyStimulus(1'b1, 3'd5, 1'b0, 2'b10, 8'h00);
    checkOutput("s1_valid", 32'(outValid8), 32'h20);
    checkOutput("s1_pending", 32'(pending8), 32'd1);
    applyStimulus(1'b1, 3'd5, 1'b0, 2'b11, 8'h00);
    checkOutput("s1_hold", 32'(outData8[5]), 32'(2'b10));

    // Same-cycle drain and refill of row 5.
    applyStimulus(1'b1, 3'd5, 1'b0, 2'b01, 8'h20);
    checkOutput("s2_data", 32'(outData8[5]), 32'(2'b01));
    checkOutput("s2_pending", 32'(pending8), 32'd1);

    // Broadcast blocked by a stalled row 3, then released.
    applyStimulus(1'b1, 3'd3, 1'b0, 2'b11, 8'h20);
    applyStimulus(1'b1, 3'd0, 1'b1, 2'b10, 8'h00);
    checkOutput("s3_blocked", 32'(outValid8), 32'h08);
    applyStimulus(1'b1, 3'd0, 1'b1, 2'b10, 8'h08);
    checkOutput("s3_valid8", 32'(outValid8), 32'hFF);
    checkOutput("s3_pending8", 32'(pending8), 32'd8);
    checkOutput("s3_pending6", 32'(pending6), 32'd6);

    // Out-of-range index on the 6-row instance.
    applyStimulus(1'b0, 3'd0, 1'b0, 2'b00, 8'hFF);
    applyStimulus(1'b1, 3'd7, 1'b0, 2'b11, 8'h00);
    checkOutput("s4_err6", 32'(idxErr6), 32'd1);
    checkOutput("s4_valid6", 32'(outValid6), 32'h00);

    // Back-to-back streaming with every consumer ready.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 3'(i % 8), 1'b0, 2'($urandom), 8'hFF);
      oneHot = 8'h01 << (i % 8);
      checkOutput("s5_onehot", 32'(outValid8), 32'(oneHot));
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 7) == 0, 2'($urandom), 8'($urandom));
    end

    // Async reset with rows 1, 4 and 6 full.
    applyStimulus(1'b0, 3'd0, 1'b0, 2'b00, 8'hFF);
    applyStimulus(1'b1, 3'd1, 1'b0, 2'b01, 8'h00);
    applyStimulus(1'b1, 3'd4, 1'b0, 2'b10, 8'h00);
    applyStimulus(1'b1, 3'd6, 1'b0, 2'b11, 8'h00);
    checkOutput("s6_before", 32'(outValid8), 32'h52);
    #2 resetn = 1'b0;
    #1;
    checkOutput("s6_valid8", 32'(outValid8), 32'h00);
    checkOutput("s6_pending8", 32'(pending8), 32'd0);
    checkOutput("s6_err6", 32'(idxErr6), 32'd0);
    resetModel();
    @(negedge clk);
    checkRegs();
    resetn = 1'b1;
    applyStimulus(1'b1, 3'd5, 1'b0, 2'b10, 8'h00);
    checkOutput("s6_again", 32'(outValid8), 32'h20);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/row_scatter.md
Name: row_scatter

Overview:
- Inverse of the row-wise OR combiner. Takes one stream of COLS-bit words, each tagged with a row index, and delivers each word to its destination row.
- Each of ROWS destinations has its own 1-entry holding register and its own valid/ready handshake.
- Sits between a shared response source and per-requester consumers, for example returning bus read data to the requester whose request produced it.
- Also supports broadcast of one word to every row.

Parameters:
- ROWS, 8, number of destination rows (>=1; need not be a power of 2).
- COLS, 2, data width per row in bits (>=1).
- IDXW, $clog2(ROWS) (minimum 1), width of the row index.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- InValid  input  1  an input word is offered.
- InReady  output  1  the input word is accepted this cycle.
- InIdx  input  IDXW  destination row index.
- InBcast  input  1  deliver the word to all rows; InIdx is ignored.
- InData  input  COLS  input word.
- OutValid  output  ROWS  per-row holding register is full.
- OutReady  input  ROWS  per-row consumer accepts the word.
- OutData  output  COLS x ROWS (unpacked [ROWS-1:0])  per-row held word.
- Pending  output  IDXW+1  number of full holding registers.
- IdxErr  output  1  sticky flag: an out-of-range index was accepted.

Behaviour:
- Reset (resetn low, asynchronous):
  - all OutValid=0, OutData=0, Pending=0, IdxErr=0.
  - Reset asserted mid-transfer drops all held words; no partial state survives.
- Row r is free when OutValid[r]=0 or (OutValid[r]=1 and OutReady[r]=1). A row drained in a cycle may be refilled in that same cycle (full throughput).
- InReady is combinational from current state, OutReady, InIdx and InBcast:
  - Unicast: InReady = row InIdx is free.
  - Broadcast: InReady = every row is free.
  - Out-of-range index (InIdx >= ROWS): InReady=1, so an illegal index never deadlocks the source.
  - InReady does not depend on InValid.
- Accept = InValid & InReady. On Accept:
  - Unicast in range: at the next edge OutData[InIdx]<=InData and OutValid[InIdx]<=1.
  - Broadcast: all rows load InData and all OutValid<=1.
  - Out-of-range: word discarded, IdxErr<=1 (sticky until reset).
- Latency: accept in cycle N makes OutValid visible in cycle N+1. There is no combinational path from InData to OutData.
- Drain: OutValid[r] & OutReady[r] with no simultaneous refill of row r clears OutValid[r] at the next edge. OutData[r] holds its value and is don't-care once invalid.
- Stability: while OutValid[r]=1 and OutReady[r]=0, OutData[r] is held stable.
- Pending:
  - Equals popcount(OutValid), registered and updated in the same cycle as OutValid.
  - Updated incrementally: +1 per fill, -1 per drain, net 0 for a same-cycle drain and refill of one row, broadcast sets it to ROWS.
  - Must always equal popcount(OutValid); verification checks this invariant.
- ROWS=1: InIdx is treated as 0 and broadcast is equivalent to unicast.
- Per-row state is a 2-state machine, EMPTY <-> FULL:
  - EMPTY -> FULL on fill.
  - FULL -> EMPTY on drain without refill.
  - FULL -> FULL on drain with refill, or on stall.

Decomposition:
- No shared package is needed. IDXW is derived locally.
- One sub-module, row_scatter_slot: the 1-entry holding register and handshake for a single row. Ports: fill, data-in, OutValid, OutReady, OutData, free. Instantiated ROWS times in a generate loop.
- The top level contains only the index decode, broadcast AND, error flag and Pending counter.

Test Plan:
1. Reset then unicast: ROWS=8, COLS=2. InIdx=5, InData=2'b10, all OutReady=0 -> next cycle OutValid=8'h20, OutData[5]=2'b10, Pending=1. A second word to row 5 sees InReady=0.
2. Same-cycle drain and refill: row 5 full, OutReady[5]=1, new word 2'b01 to row 5 -> InReady=1; next cycle OutValid[5]=1, OutData[5]=2'b01, Pending unchanged at 1.
3. Broadcast blocking: row 3 full with OutReady[3]=0, InBcast=1 -> InReady=0. Raise OutReady[3] -> accept; next cycle OutValid=8'hFF, every OutData=InData, Pending=8.
4. Out-of-range index: ROWS=6, InIdx=7, InValid=1 -> InReady=1, no OutValid change, IdxErr=1 and stays 1 through later traffic until resetn low.
5. Back-to-back streaming: indices 0..7 repeated with all OutReady=1 -> one accept per cycle, each OutValid pulse appears exactly 1 cycle after its accept, data matches, Pending never exceeds 1 per active row.
6. Async reset mid-operation: rows 1, 4 and 6 full; drop resetn between clock edges -> OutValid=0, Pending=0, IdxErr=0 immediately. After release, the first accept behaves as in scenario 1.
